// File: rtl/key_input_pkg.sv
// Shared register map and defaults for the pushbutton input port.
// Purely constants; no logic, no latency.
package key_input_pkg;
   localparam logic [1:0] ADDR_DATA     = 2'd0;
   localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
   localparam logic [1:0] ADDR_EDGE     = 2'd2;
   localparam logic [1:0] ADDR_RAW      = 2'd3;

   // 10 ms of stability at 50 MHz
   localparam int DEBOUNCE_DEFAULT = 500000;
endpackage

// File: rtl/key_debouncer.sv
// One-key synchronizer plus debouncer; pin-to-debounced latency is 2 + DEBOUNCE_CYCLES clocks.
// Free-running input path with no backpressure; any bounce before the threshold restarts the count.
module key_debouncer
   import key_input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic clk,
   input  logic reset_n,
   input  logic key_n,
   output logic pressed_sync,
   output logic debounced
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] count;

   assign pressed_sync = ~sync2;

   // The counter clears at the threshold, so it can never wrap.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1     <= 1'b1;
         sync2     <= 1'b1;
         count     <= '0;
         debounced <= 1'b0;
      end else begin
         sync1 <= key_n;
         sync2 <= sync1;
         if (pressed_sync == debounced) begin
            count <= '0;
         end else if (count == LAST) begin
            debounced <= pressed_sync;
            count     <= '0;
         end else begin
            count <= count + CW'(1);
         end
      end
   end
endmodule

// File: rtl/key_input_port.sv
// Avalon-MM pushbutton port: debounced DATA, IRQ_MASK, W1C EDGE_CAPTURE and RAW registers plus level irq.
// Read latency is 1 clock; no wait states or backpressure, so every strobe is accepted on its edge.
module key_input_port
   import key_input_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             read,
   input  logic             write,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic             irq,
   input  logic [WIDTH-1:0] keys_n
);
   logic [WIDTH-1:0] pressed_sync;
   logic [WIDTH-1:0] debounced;
   logic [WIDTH-1:0] debounced_d;
   logic [WIDTH-1:0] edge_capture;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_clr;
   logic [31:0]      rd_word;
   logic             wr_en;
   logic             rd_en;
   logic             unused_wdata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_key
      key_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk         (clk),
         .reset_n     (reset_n),
         .key_n       (keys_n[i]),
         .pressed_sync(pressed_sync[i]),
         .debounced   (debounced[i])
      );
   end

   assign wr_en        = chipselect && write;
   assign rd_en        = chipselect && read;
   assign edge_clr     = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
   assign unused_wdata = ^writedata;

   always_comb begin
      rd_word = '0;
      case (address)
         ADDR_DATA:     rd_word[WIDTH-1:0] = debounced;
         ADDR_IRQ_MASK: rd_word[WIDTH-1:0] = irq_mask;
         ADDR_EDGE:     rd_word[WIDTH-1:0] = edge_capture;
         default:       rd_word[WIDTH-1:0] = pressed_sync;
      endcase
   end

   // Set term is OR'ed after the clear so a press arriving with a W1C is kept.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         debounced_d  <= '0;
         edge_capture <= '0;
         irq_mask     <= '0;
         readdata     <= '0;
      end else begin
         debounced_d  <= debounced;
         edge_capture <= (edge_capture & ~edge_clr) | (debounced & ~debounced_d);
         if (wr_en && address == ADDR_IRQ_MASK)
            irq_mask <= writedata[WIDTH-1:0];
         if (rd_en)
            readdata <= rd_word;
      end
   end

   assign irq = |(edge_capture & irq_mask);
endmodule

// File: tb/tb_key_input_port.sv
// Bench for key_input_port: directed boundary cases then random keys and bus traffic,
// checked every cycle against a window-based behavioural model of the port.
module tb_key_input_port;
   localparam int W  = 4;
   localparam int DC = 4;

   logic          clk        = 1'b0;
   logic          reset_n    = 1'b0;
   logic [1:0]    address    = '0;
   logic          chipselect = 1'b0;
   logic          read       = 1'b0;
   logic          write      = 1'b0;
   logic [31:0]   writedata  = '0;
   logic [31:0]   readdata;
   logic          irq;
   logic [W-1:0]  keys_n     = '1;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   key_input_port #(
      .WIDTH(W),
      .DEBOUNCE_CYCLES(DC)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .chipselect(chipselect),
      .read      (read),
      .write     (write),
      .writedata (writedata),
      .readdata  (readdata),
      .irq       (irq),
      .keys_n    (keys_n)
   );

   // Model: a key's debounced level flips to v once the last DC synchronized samples all equal v.
   logic [W-1:0] m_s1   = '0;
   logic [W-1:0] m_psh [DC] = '{default: '0};
   logic [W-1:0] m_deb  = '0;
   logic [W-1:0] m_prev = '0;
   logic [W-1:0] m_ec   = '0;
   logic [W-1:0] m_mask = '0;
   logic [31:0]  m_rd   = '0;

   always @(posedge clk or negedge reset_n) begin
      logic [31:0]  nrd;
      logic [W-1:0] clr;
      logic [W-1:0] ndeb;
      logic         all1;
      logic         all0;
      if (!reset_n) begin
         m_s1 = '0; m_deb = '0; m_prev = '0; m_ec = '0; m_mask = '0; m_rd = '0;
         for (int k = 0; k < DC; k++) m_psh[k] = '0;
      end else begin
         nrd = m_rd;
         if (chipselect && read) begin
            case (address)
               2'd0:    nrd = 32'(m_deb);
               2'd1:    nrd = 32'(m_mask);
               2'd2:    nrd = 32'(m_ec);
               default: nrd = 32'(m_psh[0]);
            endcase
         end
         clr = (chipselect && write && address == 2'd2) ? writedata[W-1:0] : '0;
         ndeb = m_deb;
         for (int b = 0; b < W; b++) begin
            all1 = 1'b1;
            all0 = 1'b1;
            for (int k = 0; k < DC; k++) begin
               all1 = all1 & m_psh[k][b];
               all0 = all0 & ~m_psh[k][b];
            end
            if (all1) ndeb[b] = 1'b1;
            if (all0) ndeb[b] = 1'b0;
         end
         m_ec = (m_ec & ~clr) | (m_deb & ~m_prev);
         if (chipselect && write && address == 2'd1) m_mask = writedata[W-1:0];
         m_prev = m_deb;
         m_deb  = ndeb;
         for (int k = DC - 1; k > 0; k--) m_psh[k] = m_psh[k-1];
         m_psh[0] = m_s1;
         m_s1 = ~keys_n;
         m_rd = nrd;
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("model_irq", {31'b0, irq}, {31'b0, |(m_ec & m_mask)});
      check("model_readdata", readdata, m_rd);
   end

   task automatic cyc(input logic [W-1:0] k, input logic cs, input logic rd, input logic wr,
                      input logic [1:0] a, input logic [31:0] wd);
      keys_n = k; chipselect = cs; read = rd; write = wr; address = a; writedata = wd;
      @(negedge clk);
   endtask

   task automatic idle(input logic [W-1:0] k, input int n);
      for (int i = 0; i < n; i++) cyc(k, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
   endtask

   task automatic rd_reg(input logic [W-1:0] k, input logic [1:0] a, output logic [31:0] d);
      cyc(k, 1'b1, 1'b1, 1'b0, a, 32'd0);
      d = readdata;
   endtask

   task automatic wr_reg(input logic [W-1:0] k, input logic [1:0] a, input logic [31:0] wd);
      cyc(k, 1'b1, 1'b0, 1'b1, a, wd);
   endtask

   initial begin
      logic [31:0]  d;
      logic [31:0]  raw [8];
      logic [W-1:0] kk;
      logic [W-1:0] pat;
      int           op;
      int           b;

      repeat (3) @(negedge clk);
      check("irq_in_reset", {31'b0, irq}, 32'd0);
      reset_n = 1'b1;

      for (int a = 0; a < 4; a++) begin
         rd_reg(4'hF, 2'(a), d);
         check($sformatf("reset_read_addr%0d", a), d, 32'd0);
      end
      check("reset_irq", {31'b0, irq}, 32'd0);

      // Clean press of key0: debounced only after 2 + DC edges.
      idle(4'b1110, 5);
      rd_reg(4'b1110, 2'd0, d);  check("data_before_threshold", d, 32'h0);
      rd_reg(4'b1110, 2'd0, d);  check("data_after_threshold", d, 32'h1);
      rd_reg(4'b1110, 2'd2, d);  check("edge_key0", d, 32'h1);
      check("irq_masked_off", {31'b0, irq}, 32'd0);

      // Bounce key1 shorter than the threshold while polling RAW.
      pat = 8'b0111_0111 >> 0;
      for (int i = 0; i < 8; i++) begin
         kk = {2'b11, ~((i % 4) != 3), 1'b0};
         rd_reg(kk, 2'd3, raw[i]);
      end
      check("raw_bounce_low", raw[2], 32'h3);
      check("raw_bounce_high", raw[5], 32'h1);
      check("raw_bounce_low2", raw[6], 32'h3);
      idle(4'b1110, 8);
      rd_reg(4'b1110, 2'd0, d);  check("data_bounce_ignored", d, 32'h1);
      rd_reg(4'b1110, 2'd2, d);  check("edge_bounce_ignored", d, 32'h1);

      // Masked interrupt on key1, then W1C while still held.
      wr_reg(4'b1110, 2'd1, 32'h2);
      idle(4'b1100, 6);
      check("irq_before_capture", {31'b0, irq}, 32'd0);
      idle(4'b1100, 1);
      check("irq_on_capture", {31'b0, irq}, 32'd1);
      wr_reg(4'b1100, 2'd2, 32'h2);
      check("irq_after_w1c", {31'b0, irq}, 32'd0);
      idle(4'b1100, 10);
      check("irq_no_recapture", {31'b0, irq}, 32'd0);
      rd_reg(4'b1100, 2'd2, d);  check("edge_after_w1c", d, 32'h1);

      // W1C of bit2 on the very edge it sets, with a simultaneous read.
      idle(4'b1000, 6);
      cyc(4'b1000, 1'b1, 1'b1, 1'b1, 2'd2, 32'h4);
      check("edge_read_presets", readdata, 32'h1);
      rd_reg(4'b1000, 2'd2, d);  check("edge_set_wins", d, 32'h5);

      // Fill edge_capture, then reset mid-debounce while irq is high.
      wr_reg(4'b1000, 2'd1, 32'hF);
      idle(4'b1111, 10);
      rd_reg(4'b1111, 2'd0, d);  check("data_all_released", d, 32'h0);
      idle(4'b0000, 10);
      rd_reg(4'b0000, 2'd2, d);  check("edge_all", d, 32'hF);
      check("irq_all", {31'b0, irq}, 32'd1);
      idle(4'b0001, 2);
      #2 reset_n = 1'b0;
      #1 check("irq_async_reset", {31'b0, irq}, 32'd0);
      check("readdata_async_reset", readdata, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      rd_reg(4'b0000, 2'd2, d);  check("edge_after_reset", d, 32'h0);
      rd_reg(4'b0000, 2'd0, d);  check("data_after_reset", d, 32'h0);
      idle(4'b0000, 3);
      rd_reg(4'b0000, 2'd0, d);  check("data_redebounce_early", d, 32'h0);
      rd_reg(4'b0000, 2'd0, d);  check("data_redebounce_done", d, 32'hF);

      // Random keys and bus traffic against the model.
      kk = 4'b0000;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            b = $urandom_range(0, W - 1);
            kk[b] = ~kk[b];
         end
         op = $urandom_range(0, 3);
         cyc(kk, $urandom_range(0, 5) != 0, op[0], op[1], 2'($urandom_range(0, 3)), $urandom);
      end
      idle(kk, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
